fifo_wr_ctrl_lvl: RTL and testbench

//   Write-side controller for the async FIFO; successor to the fixed 4-bit write-pointer block.

---
 rtl/fifo_wr_ctrl_lvl.sv | 66 ++++++
 tb/tb_fifo_wr_ctrl_lvl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ctrl_lvl.sv
// Write-side controller for the async FIFO: binary/gray write pointer, RAM write port,
// registered full / almost-full / fill level, and a sticky overflow flag.
module fifo_wr_ctrl_lvl #(
    parameter int ADDR_WIDTH   = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic                  w_clk,
    input  logic                  w_rst_n,
    input  logic                  w_inc,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
    input  logic                  w_ovf_clr,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH:0]   w_ptr,
    output logic                  w_full,
    output logic                  w_afull,
    output logic [ADDR_WIDTH:0]   w_level,
    output logic                  w_ovf
);

    localparam int AW = ADDR_WIDTH;
    // Full when the gray pointers differ only in their top two bits.
    localparam logic [AW:0] FULL_MASK = (AW+1)'(3) << (AW - 1);

    logic [AW:0] wbin;
    logic [AW:0] wbin_n;
    logic [AW:0] gray_n;
    logic [AW:0] rbin;
    logic [AW:0] level_n;
    logic        acc;

    assign acc  = w_inc & ~w_full;
    assign w_en = acc;

    always_comb begin
        wbin_n  = wbin + {{AW{1'b0}}, acc};
        gray_n  = (wbin_n >> 1) ^ wbin_n;
        rbin    = '0;
        rbin[AW] = wq2_rptr[AW];
        for (int unsigned i = 1; i <= AW; i++) begin
            rbin[AW-i] = rbin[AW-i+1] ^ wq2_rptr[AW-i];
        end
        level_n = wbin_n - rbin;
    end

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            wbin    <= '0;
            w_ptr   <= '0;
            w_addr  <= '0;
            w_full  <= 1'b0;
            w_afull <= 1'b0;
            w_level <= '0;
            w_ovf   <= 1'b0;
        end else begin
            wbin    <= wbin_n;
            w_ptr   <= gray_n;
            w_addr  <= wbin_n[AW-1:0];
            w_full  <= (gray_n == (wq2_rptr ^ FULL_MASK));
            w_afull <= (level_n >= (AW+1)'(AFULL_THRESH));
            w_level <= level_n;
            w_ovf   <= (w_inc & w_full) | (w_ovf & ~w_ovf_clr);
        end
    end

endmodule

// File: tb/tb_fifo_wr_ctrl_lvl.sv
// Scoreboarded bench for fifo_wr_ctrl_lvl: a driver with an occupancy-count model queues
// expected outputs; a monitor compares them with the DUT each cycle.
module tb_fifo_wr_ctrl_lvl;

    logic       w_clk = 1'b0;
    logic       w_rst_n = 1'b0;
    logic       w_inc = 1'b0;
    logic [3:0] wq2_rptr = '0;
    logic       w_ovf_clr = 1'b0;
    logic       w_en;
    logic [2:0] w_addr;
    logic [3:0] w_ptr;
    logic       w_full;
    logic       w_afull;
    logic [3:0] w_level;
    logic       w_ovf;

    fifo_wr_ctrl_lvl #(.ADDR_WIDTH(3), .AFULL_THRESH(6)) dut (
        .w_clk(w_clk), .w_rst_n(w_rst_n), .w_inc(w_inc), .wq2_rptr(wq2_rptr),
        .w_ovf_clr(w_ovf_clr), .w_en(w_en), .w_addr(w_addr), .w_ptr(w_ptr),
        .w_full(w_full), .w_afull(w_afull), .w_level(w_level), .w_ovf(w_ovf)
    );

    always #5 w_clk = ~w_clk;

    typedef struct {
        bit       en;
        bit [2:0] addr;
        bit [3:0] ptr;
        bit       full;
        bit       afull;
        bit [3:0] level;
        bit       ovf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    bit   drv_done = 1'b0;

    // Model state: total accepted writes and reads since reset, plus flags.
    int wc = 0;
    int rc = 0;
    bit mfull = 1'b0;
    bit movf = 1'b0;

    function automatic bit [3:0] gray(input int v);
        bit [3:0] b;
        b = v[3:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic step(input bit inc, input int rnew, input bit clr, input bit rst);
        exp_t e;
        bit   acc;
        int   lvl;
        @(negedge w_clk);
        w_rst_n   = !rst;
        w_inc     = inc;
        wq2_rptr  = gray(rnew);
        w_ovf_clr = clr;
        e.en = inc && !mfull;
        if (rst) begin
            wc = 0; rc = 0; mfull = 0; movf = 0;
            e.addr = '0; e.ptr = '0; e.full = 0; e.afull = 0; e.level = '0; e.ovf = 0;
        end else begin
            acc   = inc && !mfull;
            movf  = (inc && mfull) || (movf && !clr);
            wc    = wc + int'(acc);
            rc    = rnew;
            lvl   = wc - rc;
            mfull = (lvl == 8);
            e.addr  = 3'(wc % 8);
            e.ptr   = gray(wc % 16);
            e.full  = mfull;
            e.afull = (lvl >= 6);
            e.level = 4'(lvl);
            e.ovf   = movf;
        end
        q.push_back(e);
    endtask

    // Driver: directed scenarios, then constrained-random traffic.
    initial begin
        bit r, i, c;
        int rn;
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        repeat (10) step(1, 0, 0, 0);
        for (int k = 1; k <= 4; k++) step(0, k, 0, 0);
        repeat (4) step(1, 4, 0, 0);
        step(1, 4, 1, 0);
        step(0, 4, 1, 0);
        step(0, 4, 0, 0);
        step(0, 0, 0, 1);
        repeat (20) step(1, (wc >= 2) ? wc - 2 : 0, 0, 0);
        step(0, 0, 0, 1);
        repeat (5) step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        step(1, 0, 0, 0);
        repeat (400) begin
            r  = ($urandom_range(0, 49) == 0);
            i  = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 7) == 0);
            rn = rc;
            if ($urandom_range(0, 2) == 0) rn = rc + int'($urandom_range(0, wc - rc));
            if (r) rn = 0;
            step(i, rn, c, r);
        end
        drv_done = 1'b1;
    end

    // Monitor: w_en sampled mid-cycle, registered outputs just after the edge.
    initial begin
        exp_t e;
        bit   en_s;
        forever begin
            @(negedge w_clk);
            #2 en_s = w_en;
            @(posedge w_clk);
            #1;
            if (q.size() == 0) begin
                if (!drv_done) begin
                    checks++;
                    $display("FAIL queue: got empty expected entry at %0t", $time);
                end
                break;
            end
            e = q.pop_front();
            chk("w_en",    int'(en_s),    int'(e.en));
            chk("w_addr",  int'(w_addr),  int'(e.addr));
            chk("w_ptr",   int'(w_ptr),   int'(e.ptr));
            chk("w_full",  int'(w_full),  int'(e.full));
            chk("w_afull", int'(w_afull), int'(e.afull));
            chk("w_level", int'(w_level), int'(e.level));
            chk("w_ovf",   int'(w_ovf),   int'(e.ovf));
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        checks++;
        $display("FAIL timeout: got no completion expected finish by %0t", $time);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
